// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_pkg
// Description : Shared widths, status-bit layout and refill FSM state
//               encoding for the 4-way instruction cache refill path.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

    localparam int TAG_BITS_WIDTH    = 8;
    localparam int INDEX_BITS        = 4;
    localparam int BLOCK_OFFSET_BITS = 4;
    localparam int WORD_DATA_WIDTH   = 20;
    localparam int NUM_WAYS          = 4;
    localparam int WAY_BITS          = 2;
    localparam int STATUS_BITS       = 2 * NUM_WAYS;

    // Way w owns status bits {valid, use} at {2w+1, 2w}.
    localparam int USE_BIT_IDX   = 0;
    localparam int VALID_BIT_IDX = 1;

    localparam int STATE_BITS = 3;
    localparam logic [STATE_BITS-1:0] S_IDLE   = 3'd0;
    localparam logic [STATE_BITS-1:0] S_VICTIM = 3'd1;
    localparam logic [STATE_BITS-1:0] S_REQ    = 3'd2;
    localparam logic [STATE_BITS-1:0] S_FILL   = 3'd3;
    localparam logic [STATE_BITS-1:0] S_COMMIT = 3'd4;

endpackage : icache_pkg
`default_nettype wire

// File: rtl/icache_victim_sel.sv
`default_nettype none
// ============================================================================
// Module      : icache_victim_sel
// Description : Combinational victim-way chooser. Prefers the lowest invalid
//               way, then the first way with a clear use bit scanning upward
//               from the round-robin pointer, and finally the pointer itself.
// Ports       : i_status   - status byte of the set
//               i_rr       - round-robin pointer
//               o_victim   - chosen way
//               o_fallback - every way valid and used; victim is i_rr
// Revision    : 1.0 - initial release
// ============================================================================
module icache_victim_sel
    import icache_pkg::*;
(
    input  logic [STATUS_BITS-1:0] i_status,
    input  logic [WAY_BITS-1:0]    i_rr,
    output logic [WAY_BITS-1:0]    o_victim,
    output logic                   o_fallback
);

    logic [NUM_WAYS-1:0] w_use;
    logic [NUM_WAYS-1:0] w_valid;
    logic                w_found_inv;
    logic [WAY_BITS-1:0] w_inv_way;
    logic                w_found_free;
    logic [WAY_BITS-1:0] w_free_way;
    logic [WAY_BITS-1:0] w_scan_way;

    always_comb begin
        w_use        = '0;
        w_valid      = '0;
        w_found_inv  = 1'b0;
        w_inv_way    = '0;
        w_found_free = 1'b0;
        w_free_way   = i_rr;
        w_scan_way   = i_rr;
        for (int k = 0; k < NUM_WAYS; k++) begin
            w_use[k]   = i_status[2*k + USE_BIT_IDX];
            w_valid[k] = i_status[2*k + VALID_BIT_IDX];
        end
        // Scan downward so the last hit, i.e. the lowest way, wins.
        for (int k = NUM_WAYS - 1; k >= 0; k--) begin
            if (!w_valid[k]) begin
                w_found_inv = 1'b1;
                w_inv_way   = WAY_BITS'(k);
            end
        end
        // Same trick for the rotating scan: smallest distance from i_rr wins.
        for (int k = NUM_WAYS - 1; k >= 0; k--) begin
            w_scan_way = i_rr + WAY_BITS'(k);
            if (!w_use[w_scan_way]) begin
                w_found_free = 1'b1;
                w_free_way   = w_scan_way;
            end
        end
        if (w_found_inv) begin
            o_victim   = w_inv_way;
            o_fallback = 1'b0;
        end else if (w_found_free) begin
            o_victim   = w_free_way;
            o_fallback = 1'b0;
        end else begin
            o_victim   = i_rr;
            o_fallback = 1'b1;
        end
    end

endmodule : icache_victim_sel
`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill_ctrl
// Description : Miss-refill controller for the 4-way instruction cache.
//               Accepts one miss, invalidates the chosen victim way, fetches
//               the 16-word block and streams it into the data array, then
//               commits tag and status last so a partial block is never valid.
// Ports       : clk/arst            - clock, async active-high reset
//               i_miss_*/o_miss_ready - miss request from lookup pipeline
//               o_mem_req_*/i_mem_*   - block read request / response words
//               o_data_wr_*          - data array word writes
//               o_tag_wr_*           - tag array write
//               o_status_wr_*        - status byte write for the set
//               o_refill_done        - one-cycle pulse on commit
// Revision    : 1.0 - initial release
// ============================================================================
module icache_refill_ctrl
    import icache_pkg::*;
(
    input  logic                                clk,
    input  logic                                arst,
    input  logic                                i_miss_valid,
    input  logic [TAG_BITS_WIDTH-1:0]           i_miss_tag,
    input  logic [INDEX_BITS-1:0]               i_miss_index,
    input  logic [STATUS_BITS-1:0]              i_miss_status,
    output logic                                o_miss_ready,
    output logic                                o_mem_req_valid,
    output logic [TAG_BITS_WIDTH+INDEX_BITS-1:0] o_mem_req_addr,
    input  logic                                i_mem_req_ready,
    input  logic                                i_mem_rsp_valid,
    input  logic [WORD_DATA_WIDTH-1:0]          i_mem_rsp_data,
    output logic                                o_data_wr_en,
    output logic [INDEX_BITS-1:0]               o_data_wr_index,
    output logic [WAY_BITS-1:0]                 o_data_wr_way,
    output logic [BLOCK_OFFSET_BITS-1:0]        o_data_wr_offset,
    output logic [WORD_DATA_WIDTH-1:0]          o_data_wr_word,
    output logic                                o_tag_wr_en,
    output logic [WAY_BITS-1:0]                 o_tag_wr_way,
    output logic [TAG_BITS_WIDTH-1:0]           o_tag_wr_tag,
    output logic                                o_status_wr_en,
    output logic [STATUS_BITS-1:0]              o_status_wr_data,
    output logic                                o_refill_done
);

    localparam logic [BLOCK_OFFSET_BITS-1:0] c_LAST_OFFSET = '1;

    logic [STATE_BITS-1:0]        r_state;
    logic [STATE_BITS-1:0]        w_state_next;
    logic [TAG_BITS_WIDTH-1:0]    r_tag;
    logic [INDEX_BITS-1:0]        r_index;
    logic [STATUS_BITS-1:0]       r_status;
    logic [WAY_BITS-1:0]          r_victim;
    logic                         r_fallback;
    logic [WAY_BITS-1:0]          r_rr;
    logic [BLOCK_OFFSET_BITS-1:0] r_cnt;

    logic [WAY_BITS-1:0]          w_victim;
    logic                         w_fallback;
    logic [STATUS_BITS-1:0]       w_status_inv;
    logic [STATUS_BITS-1:0]       w_status_commit;
    logic                         w_word_wr;

    // Victim is chosen from the live miss status so it is already registered
    // when VICTIM starts; way outputs then stay stable through COMMIT.
    icache_victim_sel u_victim_sel (
        .i_status   (i_miss_status),
        .i_rr       (r_rr),
        .o_victim   (w_victim),
        .o_fallback (w_fallback)
    );

    always_comb begin
        w_status_inv    = r_status;
        w_status_commit = r_status;
        for (int k = 0; k < NUM_WAYS; k++) begin
            if (r_victim == WAY_BITS'(k)) begin
                w_status_inv[2*k + USE_BIT_IDX]      = 1'b0;
                w_status_inv[2*k + VALID_BIT_IDX]    = 1'b0;
                w_status_commit[2*k + USE_BIT_IDX]   = 1'b1;
                w_status_commit[2*k + VALID_BIT_IDX] = 1'b1;
            end else if (r_fallback) begin
                // Every way was used: age the others so they become candidates.
                w_status_commit[2*k + USE_BIT_IDX]   = 1'b0;
            end
        end
    end

    assign w_word_wr = (r_state == S_FILL) && i_mem_rsp_valid;

    always_comb begin
        w_state_next     = r_state;
        o_miss_ready     = 1'b0;
        o_mem_req_valid  = 1'b0;
        o_tag_wr_en      = 1'b0;
        o_status_wr_en   = 1'b0;
        o_status_wr_data = '0;
        o_refill_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_miss_ready = 1'b1;
                if (i_miss_valid) begin
                    w_state_next = S_VICTIM;
                end
            end
            S_VICTIM: begin
                o_status_wr_en   = 1'b1;
                o_status_wr_data = w_status_inv;
                w_state_next     = S_REQ;
            end
            S_REQ: begin
                o_mem_req_valid = 1'b1;
                if (i_mem_req_ready) begin
                    w_state_next = S_FILL;
                end
            end
            S_FILL: begin
                if (w_word_wr && (r_cnt == c_LAST_OFFSET)) begin
                    w_state_next = S_COMMIT;
                end
            end
            S_COMMIT: begin
                o_tag_wr_en      = 1'b1;
                o_status_wr_en   = 1'b1;
                o_status_wr_data = w_status_commit;
                o_refill_done    = 1'b1;
                w_state_next     = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state    <= S_IDLE;
            r_tag      <= '0;
            r_index    <= '0;
            r_status   <= '0;
            r_victim   <= '0;
            r_fallback <= 1'b0;
            r_rr       <= '0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == S_IDLE) && i_miss_valid) begin
                r_tag      <= i_miss_tag;
                r_index    <= i_miss_index;
                r_status   <= i_miss_status;
                r_victim   <= w_victim;
                r_fallback <= w_fallback;
            end
            if (r_state == S_VICTIM) begin
                r_status <= w_status_inv;
            end
            if (w_word_wr) begin
                r_cnt <= (r_cnt == c_LAST_OFFSET) ? '0 : r_cnt + 1'b1;
            end
            if (r_state == S_COMMIT) begin
                r_rr <= r_victim + 2'd1;
            end
        end
    end

    assign o_mem_req_addr   = {r_tag, r_index};
    assign o_data_wr_en     = w_word_wr;
    assign o_data_wr_index  = r_index;
    assign o_data_wr_way    = r_victim;
    assign o_data_wr_offset = r_cnt;
    assign o_data_wr_word   = w_word_wr ? i_mem_rsp_data : '0;
    assign o_tag_wr_way     = r_victim;
    assign o_tag_wr_tag     = r_tag;

endmodule : icache_refill_ctrl
`default_nettype wire
